// File: rtl/booth_mult_32_seq_pkg.sv
// Shared constants for the sequential radix-2 Booth multiplier.
// Also holds the 1-bit full-adder cell used by the add/sub unit.
package booth_mult_32_seq_pkg;

    localparam int DATA_WIDTH       = 32;
    localparam int DATA_INDEX_LIMIT = DATA_WIDTH - 1;
    localparam int CNT_WIDTH        = 6;
    localparam int MULT_STEPS       = 32;

    localparam logic [1:0] MULT_ST_IDLE   = 2'b00;
    localparam logic [1:0] MULT_ST_RUN    = 2'b01;
    localparam logic [1:0] MULT_ST_FINISH = 2'b10;

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
        return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
    endfunction

endpackage

// File: rtl/booth_mult_32_seq_add_sub_33.sv
// 33-bit ripple add/sub: sum = a + b when sub=0, a - b when sub=1.
// The final carry-out is deliberately dropped.
module booth_mult_32_seq_add_sub_33
    import booth_mult_32_seq_pkg::*;
(
    input  logic [DATA_WIDTH:0] a,
    input  logic [DATA_WIDTH:0] b,
    input  logic                sub,
    output logic [DATA_WIDTH:0] sum
);

    logic [DATA_WIDTH:0] b_x;
    logic [1:0]          fa;
    logic                carry;

    // Subtract is a + ~b + 1: invert b and inject the 1 as the first carry.
    assign b_x = b ^ {(DATA_WIDTH + 1){sub}};

    always_comb begin
        // NOTE: every variable written here gets a value before any branch or loop, so no latch is inferred.
        carry = sub;
        sum   = '0;
        fa    = '0;
        for (int i = 0; i <= DATA_WIDTH; i++) begin
            fa     = full_add(a[i], b_x[i], carry);
            sum[i] = fa[0];
            carry  = fa[1];
        end
    end

endmodule

// File: rtl/booth_mult_32_seq.sv
// Multi-cycle signed 32x32->64 radix-2 Booth multiplier, one step per clock.
// Optional OVF output enabled by defining MULT_OVF_FLAG_EN.
module booth_mult_32_seq
    import booth_mult_32_seq_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [DATA_WIDTH-1:0] HI,
`ifdef MULT_OVF_FLAG_EN
    output logic                  OVF,
`endif
    output logic [DATA_WIDTH-1:0] LO
);

    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  count;
    logic [DATA_WIDTH:0]   acc;
    logic [DATA_WIDTH:0]   mcand;
    logic [DATA_WIDTH-1:0] q;
    logic                  q_m1;

    logic                  sub;
    logic [DATA_WIDTH:0]   sum;
    logic [DATA_WIDTH:0]   acc_op;
    logic [DATA_WIDTH:0]   acc_sh;
    logic [DATA_WIDTH-1:0] q_sh;
    logic                  last_step;

    // Pair 10 subtracts; pair 01 adds; 00/11 keep ACC, so the unit's output is ignored.
    assign sub = (q[0] == 1'b1) && (q_m1 == 1'b0);

    booth_mult_32_seq_add_sub_33 add_sub_33 (
        .a   (acc),
        .b   (mcand),
        .sub (sub),
        .sum (sum)
    );

    assign acc_op    = (q[0] ^ q_m1) ? sum : acc;
    assign acc_sh    = {acc_op[DATA_WIDTH], acc_op[DATA_WIDTH:1]};
    assign q_sh      = {acc_op[0], q[DATA_INDEX_LIMIT:1]};
    assign last_step = (count == CNT_WIDTH'(MULT_STEPS - 1));

    assign BUSY = (state == MULT_ST_RUN);
    assign DONE = (state == MULT_ST_FINISH);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            // NOTE: all datapath registers are reset, not just the FSM, so a reset mid-run leaves no stale product.
            state <= MULT_ST_IDLE;
            count <= '0;
            acc   <= '0;
            mcand <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            HI    <= '0;
            LO    <= '0;
`ifdef MULT_OVF_FLAG_EN
            OVF   <= 1'b0;
`endif
        end else begin
            case (state)
                MULT_ST_IDLE: begin
                    if (START) begin
                        mcand <= {A[DATA_INDEX_LIMIT], A};
                        q     <= B;
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        count <= '0;
                        state <= MULT_ST_RUN;
                    end
                end
                MULT_ST_RUN: begin
                    acc   <= acc_sh;
                    q     <= q_sh;
                    q_m1  <= q[0];
                    count <= count + CNT_WIDTH'(1);
                    if (last_step) begin
                        state <= MULT_ST_FINISH;
                        HI    <= acc_sh[DATA_WIDTH-1:0];
                        LO    <= q_sh;
`ifdef MULT_OVF_FLAG_EN
                        OVF   <= (acc_sh[DATA_WIDTH-1:0] != {DATA_WIDTH{q_sh[DATA_INDEX_LIMIT]}});
`endif
                    end
                end
                MULT_ST_FINISH: state <= MULT_ST_IDLE;
                default:        state <= MULT_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_32_seq.sv
// Scoreboard bench for booth_mult_32_seq; define MULT_OVF_FLAG_EN to also check OVF.
`timescale 1ns/1ps
module tb_booth_mult_32_seq;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        BUSY, DONE;
    logic [31:0] HI, LO;
`ifdef MULT_OVF_FLAG_EN
    logic        OVF;
`endif

    int   errors = 0;
    int   checks = 0;
    int   done_count = 0;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    booth_mult_32_seq dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .HI    (HI),
`ifdef MULT_OVF_FLAG_EN
        .OVF   (OVF),
`endif
        .LO    (LO)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: every DONE pulse pops one expected result.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (DONE) begin
            done_count++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("product", {HI, LO}, {e.hi, e.lo});
`ifdef MULT_OVF_FLAG_EN
                check("ovf", 64'(OVF), 64'(e.ovf));
`endif
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push,
                         input logic [31:0] hi, input logic [31:0] lo, input logic ovf);
        @(negedge CLK);
        A = a;
        B = b;
        START = 1'b1;
        if (push) exp_q.push_back('{hi: hi, lo: lo, ovf: ovf});
        @(posedge CLK);
        #1;
        START = 1'b0;
    endtask

    // Called right after issue(): checks latency and BUSY width, leaves time at DONE+1.
    task automatic wait_done(input string name);
        int cyc = 0;
        int busy_cnt = 0;
        while (!DONE && cyc < 100) begin
            if (BUSY) busy_cnt++;
            @(posedge CLK);
            #1;
            cyc++;
        end
        check({name, "_latency"}, 64'(cyc), 64'd32);
        check({name, "_busy"}, 64'(busy_cnt), 64'd32);
        @(posedge CLK);
        #1;
        check({name, "_done_pulse"}, 64'({DONE, BUSY}), 64'd0);
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input logic ovf);
        issue(a, b, 1'b1, hi, lo, ovf);
        wait_done(name);
    endtask

    initial begin
        int cyc;
        int last;
        int seen;
        int dc;

        #12;
        check("reset_state", {30'd0, BUSY, DONE, HI}, 64'd0);
        check("reset_lo", 64'(LO), 64'd0);
        @(negedge CLK);
        RST = 1'b1;

        // Basic product, then check HI/LO hold in IDLE.
        run_op("basic", 32'd22, 32'd1, 32'h0, 32'h16, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        check("hold_lo", 64'(LO), 64'h16);

        // Reset mid-run clears everything before the next edge.
        issue(32'd7, 32'd5, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (9) @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        check("midrst_out", {30'd0, BUSY, DONE, HI}, 64'd0);
        check("midrst_lo", 64'(LO), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check("midrst_idle", 64'({BUSY, DONE}), 64'd0);

        // Signed and corner cases.
        run_op("neg1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("nine", 32'd9, 32'hFFFF_FFF5, 32'hFFFF_FFFF, 32'hFFFF_FF9D, 1'b0);
        run_op("minsq", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b1);
        run_op("three", 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);

        // START while busy and during FINISH is ignored.
        issue(32'd11, 32'd9, 1'b1, 32'h0, 32'd99, 1'b0);
        dc = done_count;
        repeat (4) @(posedge CLK);
        @(negedge CLK);
        A = 32'd2;
        B = 32'd2;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        cyc = 0;
        while (!DONE && cyc < 100) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("ign_done_seen", 64'(DONE), 64'd1);
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        check("ign_finish_idle", 64'({BUSY, DONE}), 64'd0);
        repeat (40) @(posedge CLK);
        #1;
        check("ign_single_done", 64'(done_count - dc), 64'd1);
        check("ign_lo_held", 64'(LO), 64'd99);

        // Back-to-back with START held high.
        @(negedge CLK);
        A = 32'd1;
        B = 32'd0;
        START = 1'b1;
        repeat (3) exp_q.push_back('{hi: 32'h0, lo: 32'h0, ovf: 1'b0});
        cyc = 0;
        last = 0;
        seen = 0;
        while (seen < 3 && cyc < 200) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (DONE) begin
                if (seen > 0) check("b2b_interval", 64'(cyc - last), 64'd34);
                last = cyc;
                seen++;
            end
        end
        START = 1'b0;
        check("b2b_count", 64'(seen), 64'd3);

        repeat (40) @(posedge CLK);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
